// File: rtl/oam_dma.sv
// Sprite DMA engine: stalls the CPU and copies one 256-byte page
// into the PPU OAM data port, reading on even and writing on odd cycles.
module oam_dma #(
  parameter int              ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_rdy,
  output logic              dma_oe,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_we,
  output logic [7:0]        dma_wdata,
  input  logic [7:0]        dma_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t     state, state_n;
  logic [7:0] page, page_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] latch, latch_n;
  logic       odd;
  logic       trig;

  assign trig = cpu_we && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      page  <= '0;
      cnt   <= '0;
      latch <= '0;
      odd   <= 1'b0;
    end else begin
      state <= state_n;
      page  <= page_n;
      cnt   <= cnt_n;
      latch <= latch_n;
      odd   <= ~odd;
    end
  end

  // Outputs decode from state only, so reset drops them without a clock.
  always_comb begin
    state_n  = state;
    page_n   = page;
    cnt_n    = cnt;
    latch_n  = latch;
    cpu_rdy  = 1'b0;
    dma_oe   = 1'b0;
    dma_we   = 1'b0;
    dma_addr = '0;
    unique case (state)
      IDLE: begin
        cpu_rdy = 1'b1;
        if (trig) begin
          page_n  = cpu_wdata;
          cnt_n   = 8'd0;
          state_n = HALT;
        end
      end
      HALT: begin
        state_n = odd ? READ : ALIGN;
      end
      ALIGN: begin
        state_n = READ;
      end
      READ: begin
        dma_oe   = 1'b1;
        dma_addr = ADDR_W'({page, cnt});
        latch_n  = dma_rdata;
        state_n  = WRITE;
      end
      WRITE: begin
        dma_oe   = 1'b1;
        dma_we   = 1'b1;
        dma_addr = OAM_DATA_ADDR;
        if (cnt == 8'hFF) begin
          cnt_n   = 8'd0;
          state_n = IDLE;
        end else begin
          cnt_n   = cnt + 8'd1;
          state_n = READ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = ~cpu_rdy;
  assign dma_wdata = latch;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: RAM model plus a read/write scoreboard
// filled at trigger time and drained by a bus monitor.
module tb_oam_dma;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_rdy;
  logic        dma_oe;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        busy;

  logic [7:0]  mem [65536];
  logic        tb_odd;
  logic [15:0] rq [$];
  logic [7:0]  wq [$];
  int          pass_cnt;
  int          total;

  oam_dma dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdy   (cpu_rdy),
    .dma_oe    (dma_oe),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dma_rdata = mem[dma_addr];

  // Reference cycle parity, independent of the DUT.
  always @(posedge clk or posedge reset)
    if (reset) tb_odd <= 1'b0;
    else       tb_odd <= ~tb_odd;

  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  // Bus monitor: every DMA access must match the head of a queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (dma_oe && !dma_we) begin
        total++;
        if (rq.size() == 0) begin
          $display("FAIL unexpected_read addr=%h", dma_addr);
        end else begin
          logic [15:0] ea;
          ea = rq.pop_front();
          if (dma_addr !== ea || tb_odd !== 1'b0)
            $display("FAIL read addr=%h odd=%b want addr=%h odd=0",
                     dma_addr, tb_odd, ea);
          else pass_cnt++;
        end
      end
      if (dma_we) begin
        total++;
        if (wq.size() == 0) begin
          $display("FAIL unexpected_write data=%h", dma_wdata);
        end else begin
          logic [7:0] ed;
          ed = wq.pop_front();
          if (dma_addr !== 16'h2004 || dma_wdata !== ed ||
              tb_odd !== 1'b1 || dma_oe !== 1'b1)
            $display("FAIL write addr=%h data=%h odd=%b want 2004 %h 1",
                     dma_addr, dma_wdata, tb_odd, ed);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic check_idle(input string nm);
    total++;
    if (cpu_rdy !== 1'b1 || busy !== 1'b0 ||
        dma_oe !== 1'b0 || dma_we !== 1'b0)
      $display("FAIL %s rdy=%b busy=%b oe=%b we=%b want 1 0 0 0",
               nm, cpu_rdy, busy, dma_oe, dma_we);
    else pass_cnt++;
  endtask

  task automatic start_dma(input logic [7:0] page, input logic halt_odd);
    int n;
    n = 0;
    @(negedge clk);
    while (tb_odd !== ~halt_odd && n < 4) begin
      @(negedge clk);
      n++;
    end
    cpu_addr  = 16'h4014;
    cpu_wdata = page;
    cpu_we    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rq.push_back({page, 8'(i)});
      wq.push_back(pat({page, 8'(i)}));
    end
    @(negedge clk);
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic wait_done(input string nm, input int exp_low,
                           input int exp_off, input bit poke);
    int low, off, bad_busy;
    low = 0;
    off = 0;
    bad_busy = 0;
    while (cpu_rdy !== 1'b1 && low < 2000) begin
      if (busy !== 1'b1) bad_busy++;
      if (!dma_oe) off++;
      low++;
      if (poke && low == 100) begin
        cpu_addr  = 16'h4014;
        cpu_wdata = 8'h07;
        cpu_we    = 1'b1;
      end
      if (poke && low == 103) begin
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
      end
      @(negedge clk);
    end
    total++;
    if (low !== exp_low)
      $display("FAIL %s_stall got=%0d want=%0d", nm, low, exp_low);
    else pass_cnt++;
    total++;
    if (off !== exp_off || bad_busy !== 0)
      $display("FAIL %s_halt_cycles got=%0d busyerr=%0d want=%0d 0",
               nm, off, bad_busy, exp_off);
    else pass_cnt++;
    total++;
    if (rq.size() !== 0 || wq.size() !== 0)
      $display("FAIL %s_left rq=%0d wq=%0d want 0 0",
               nm, rq.size(), wq.size());
    else pass_cnt++;
    check_idle({nm, "_end"});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++;
    if (dma_addr !== 16'h0000 || dma_wdata !== 8'h00)
      $display("FAIL reset_bus addr=%h data=%h want 0000 00",
               dma_addr, dma_wdata);
    else pass_cnt++;
    check_idle("reset_asserted");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_idle("reset_idle");
    end
  endtask

  task automatic test_odd_halt();
    start_dma(8'h02, 1'b1);
    wait_done("odd", 513, 1, 1'b0);
  endtask

  task automatic test_even_halt();
    start_dma(8'h02, 1'b0);
    wait_done("even", 514, 2, 1'b1);
  endtask

  task automatic test_no_trigger();
    @(negedge clk);
    cpu_addr  = 16'h4015;
    cpu_wdata = 8'h02;
    cpu_we    = 1'b1;
    @(negedge clk);
    cpu_addr = 16'h4014;
    cpu_we   = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_idle("no_trigger");
    end
    cpu_addr = 16'h0000;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    start_dma(8'h03, 1'b1);
    while (!(dma_oe && !dma_we && dma_addr == 16'h0340) && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 400) $display("FAIL mid_reach got=timeout want=0340");
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    check_idle("mid_reset");
    rq.delete();
    wq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start_dma(8'h04, 1'b0);
    wait_done("restart", 514, 2, 1'b0);
  endtask

  task automatic test_page_ff();
    start_dma(8'hFF, 1'b1);
    wait_done("page_ff", 513, 1, 1'b0);
    repeat (8) begin
      @(negedge clk);
      check_idle("page_ff_after");
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total     = 0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    reset     = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
    test_reset();
    test_odd_halt();
    test_even_halt();
    test_no_trigger();
    test_reset_mid();
    test_page_ff();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite-DMA engine on the CPU bus, directly upstream of the CPU sequencer's bus-ready input.
- A CPU store to the DMA trigger register latches a source page and stalls the sequencer by deasserting cpu_rdy.
- While the CPU is stalled, the block owns the bus and copies 256 bytes from the page at {page,00}..{page,FF} to the PPU OAM data port.
- It then releases the bus and the CPU resumes.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address written for every byte.
- ADDR_W, 16, bus address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cpu_addr  input  ADDR_W  CPU bus address, valid while the CPU owns the bus.
- cpu_wdata  input  8  CPU write data.
- cpu_we  input  1  CPU write strobe.
- cpu_rdy  output  1  bus-ready to the sequencer; 0 freezes the sequencer state.
- dma_oe  output  1  1 = DMA drives address/we/data; the bus mux selects DMA over the CPU.
- dma_addr  output  ADDR_W  DMA bus address.
- dma_we  output  1  DMA write strobe.
- dma_wdata  output  8  DMA write data.
- dma_rdata  input  8  bus read data, sampled at the end of READ cycles.
- busy  output  1  1 from trigger acceptance until transfer done.

Behaviour:
Interface:
- One clock, clk. Reset is asynchronous and active-high, port reset.

Reset:
- state=IDLE, page=0, cnt=0, latch=0, odd=0.
- Outputs: cpu_rdy=1, busy=0, dma_oe=0, dma_we=0, dma_addr=0, dma_wdata=0.

Parity:
- odd toggles every clk, free-running.
- All READ cycles occur in cycles with odd=0; all WRITE cycles occur with odd=1.

Trigger:
- Accepted in a cycle where state=IDLE, cpu_we=1 and cpu_addr==DMA_REG_ADDR.
- On acceptance: page<=cpu_wdata, cnt<=0, state<=HALT.
- The CPU write cycle itself completes normally because cpu_rdy=1 in that cycle.
- Writes to any other address, and reads of DMA_REG_ADDR, have no effect.

States:
- IDLE: cpu_rdy=1, dma_oe=0, busy=0.
- HALT: cpu_rdy=0, busy=1, dma_oe=0. Exactly 1 cycle. Next state is READ if odd=1 now, else ALIGN.
- ALIGN: cpu_rdy=0, dma_oe=0. 1 cycle, then READ.
- READ: dma_oe=1, dma_we=0, dma_addr={page,cnt}. latch<=dma_rdata at the clock edge. Next state WRITE.
- WRITE: dma_oe=1, dma_we=1, dma_addr=OAM_DATA_ADDR, dma_wdata=latch.
  - If cnt==8'hFF: state<=IDLE, cnt<=0.
  - Else: cnt<=cnt+1, state<=READ.

Output timing:
- cpu_rdy = (state==IDLE), decoded from the state register only, with no combinational path from cpu_* inputs.
- busy = ~cpu_rdy.

Latency:
- cpu_rdy is low for 513 cycles if HALT is entered with odd=1, or 514 cycles if entered with odd=0.
- cpu_rdy returns high in the cycle after the final WRITE.

Boundaries:
- cnt is 8 bits. page never increments, so page FF reads FF00..FFFF and stops, with no wrap into 0000.
- A trigger write while busy is impossible because the CPU is stalled; the block ignores cpu_we whenever state!=IDLE.
- Reset mid-transfer returns immediately to IDLE with cpu_rdy=1 and drops dma_oe/dma_we asynchronously. The partial transfer is abandoned, and the next trigger restarts at cnt=0.
- dma_wdata holds the last latch value outside WRITE. Only dma_we qualifies it.

Test Plan:
- Reset, then 10 idle cycles -> cpu_rdy=1, busy=0, dma_oe=0, dma_we=0 throughout. An asserted reset during any state forces these values without waiting for clk.
- Preload RAM[0x0200+i]=i^0x5A. Write 0x02 to 0x4014 such that HALT has odd=1 -> cpu_rdy low exactly 513 cycles. READ addresses are 0x0200..0x02FF in order, 256 WRITEs go to 0x2004 with data i^0x5A, and cpu_rdy rises after the 256th WRITE.
- Same as above but HALT entered with odd=0 -> one ALIGN cycle with dma_oe=0, stall length 514, and data identical.
- Write 0x02 to 0x4015, and read 0x4014 -> no state change, cpu_rdy stays 1.
- Trigger page 0x03 and assert reset when cnt=0x40 -> immediately cpu_rdy=1 and dma_oe=0. A new trigger with page 0x04 then starts reading at 0x0400.
- Trigger page 0xFF -> last READ is at 0xFFFF, followed by WRITE, then IDLE, with no access to 0x0000 and dma_addr never exceeding 0xFFFF.
